// File: rtl/sm_arb_defs_pkg.sv
// Shared definitions for the round-robin arbiter: FSM state encoding and
// a constant-evaluable clog2 used to size index and counter fields.
package sm_arb_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2,
    ERR   = 2'd3
  } arb_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sm_rr_arbiter_rr_pick.sv
// Rotating-priority picker: the requester just after 'owner' has top priority.
// Rotate req so owner+1 lands at bit 0, take the lowest set bit, rotate back.
module rr_pick
  import sm_arb_defs::*;
#(
  parameter int N  = 4,
  parameter int OW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [OW-1:0] owner,
  output logic [OW-1:0] winner,
  output logic          valid
);

  localparam logic [OW:0] NV = (OW+1)'(N);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] shifted;
  logic [N-1:0]   rot;
  logic [OW:0]    base;
  logic [OW:0]    sum;
  logic [OW-1:0]  idx;

  // Rotate, fixed-priority pick on the rotated vector, then un-rotate (mod N).
  always_comb begin
    dbl     = {req, req};
    base    = {1'b0, owner} + 1'b1;          // may equal N: shift by N is identity
    shifted = dbl >> base;
    rot     = shifted[N-1:0];
    idx     = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (rot[i]) idx = i[OW-1:0];
    end
    sum = {1'b0, idx} + base;                // < 2N, fits in OW+1 bits
    if (sum >= NV) sum = sum - NV;
    winner = sum[OW-1:0];
    valid  = |req;
  end

endmodule

// File: rtl/sm_rr_arbiter.sv
// Round-robin arbiter sharing one sequential resource between N requesters.
// Three paragraphs: state register, next-state/next-output logic, registered
// outputs. An owner may hold the grant for at most MAX_HOLD cycles; holding
// longer parks the FSM in ERR until that owner releases its request.
module sm_rr_arbiter
  import sm_arb_defs::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic [N-1:0]        req,
  output logic [N-1:0]        gnt,
  output logic [clog2(N)-1:0] owner,
  output logic                busy,
  output logic                err
);

  localparam int OW = clog2(N);
  localparam int HW = clog2(MAX_HOLD) + 1;
  localparam logic [OW-1:0] OWNER_RST = OW'(N-1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD-1);

  arb_state_e     state, state_nx;
  logic [N-1:0]   gnt_nx;
  logic [OW-1:0]  owner_nx;
  logic           busy_nx, err_nx;
  logic [HW-1:0]  hold_cnt, hold_nx;
  logic [OW-1:0]  pick_idx;
  logic           pick_vld;

  rr_pick #(.N(N), .OW(OW)) u_pick (
    .req    (req),
    .owner  (owner),
    .winner (pick_idx),
    .valid  (pick_vld)
  );

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and next output values; owner is kept everywhere except a new
  // grant so a dropped or overrunning owner gets lowest priority next time.
  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    owner_nx = owner;
    busy_nx  = busy;
    err_nx   = err;
    hold_nx  = hold_cnt;
    case (state)
      IDLE: begin
        gnt_nx  = '0;
        busy_nx = 1'b0;
        err_nx  = 1'b0;
        if (pick_vld) begin
          state_nx = GRANT;
          owner_nx = pick_idx;
          gnt_nx   = N'(1) << pick_idx;
          busy_nx  = 1'b1;
          hold_nx  = '0;
        end
      end
      GRANT: begin
        hold_nx = hold_cnt + 1'b1;
        // Release takes precedence over overrun in the same cycle.
        if (!req[owner]) begin
          state_nx = GAP;
          gnt_nx   = '0;
          busy_nx  = 1'b0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nx = ERR;
          gnt_nx   = '0;
          err_nx   = 1'b1;
        end
      end
      GAP: begin
        state_nx = IDLE;
        gnt_nx   = '0;
        busy_nx  = 1'b0;
        err_nx   = 1'b0;
      end
      ERR: begin
        gnt_nx = '0;
        if (!req[owner]) begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
          err_nx   = 1'b0;
        end
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = '0;
        busy_nx  = 1'b0;
        err_nx   = 1'b0;
        hold_nx  = '0;
      end
    endcase
  end

  // Registered outputs and hold counter.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      gnt      <= '0;
      owner    <= OWNER_RST;
      busy     <= 1'b0;
      err      <= 1'b0;
      hold_cnt <= '0;
    end else begin
      gnt      <= gnt_nx;
      owner    <= owner_nx;
      busy     <= busy_nx;
      err      <= err_nx;
      hold_cnt <= hold_nx;
    end
  end

endmodule

// File: tb/tb_sm_rr_arbiter.sv
// Bench for sm_rr_arbiter: directed scenarios with literal expectations,
// then randomized requests (with occasional async reset pulses), all checked
// every cycle against a phase/ownership model of the arbiter.
module tb_sm_rr_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;

  localparam int P_IDLE  = 0;
  localparam int P_GRANT = 1;
  localparam int P_GAP   = 2;
  localparam int P_ERR   = 3;

  logic         clk;
  logic         nrst;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [1:0]   owner;
  logic         busy;
  logic         err;

  int errors = 0;
  int checks = 0;

  sm_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .nrst  (nrst),
    .req   (req),
    .gnt   (gnt),
    .owner (owner),
    .busy  (busy),
    .err   (err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: which phase we are in, who owns, how many grant cycles shown so far.
  int m_phase, m_owner, m_held;

  always @(posedge clk or negedge nrst) begin
    int ph, ow, hd;
    if (!nrst) begin
      m_phase <= P_IDLE;
      m_owner <= N-1;
      m_held  <= 0;
    end else begin
      ph = m_phase; ow = m_owner; hd = m_held;
      case (m_phase)
        P_IDLE: if (req != 0) begin
          for (int k = 1; k <= N; k++) begin
            if (req[(m_owner + k) % N]) begin
              ow = (m_owner + k) % N;
              break;
            end
          end
          ph = P_GRANT;
          hd = 1;
        end
        P_GRANT: begin
          if (!req[m_owner])        ph = P_GAP;
          else if (m_held == MAX_HOLD) ph = P_ERR;
          else                      hd = m_held + 1;
        end
        P_GAP: ph = P_IDLE;
        default: if (!req[m_owner]) ph = P_IDLE;
      endcase
      m_phase <= ph;
      m_owner <= ow;
      m_held  <= hd;
    end
  end

  // Per-cycle comparison, sampled shortly after each rising edge.
  always @(posedge clk) begin
    logic [N-1:0] eg;
    #2;
    eg = (m_phase == P_GRANT) ? N'(1) << m_owner : '0;
    chk("model_gnt",   32'(gnt),   32'(eg));
    chk("model_owner", 32'(owner), 32'(m_owner));
    chk("model_busy",  32'(busy),  32'((m_phase == P_GRANT) || (m_phase == P_ERR)));
    chk("model_err",   32'(err),   32'(m_phase == P_ERR));
  end

  task automatic wait_grant(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (gnt != 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int order[$];
    logic [N-1:0] prev_gnt, r;
    int held, cnt;
    bit ok;

    // 1: reset with all requesting
    nrst = 1'b0;
    req  = 4'b1111;
    @(negedge clk);
    chk("t1_rst_gnt",   32'(gnt),   32'h0);
    chk("t1_rst_owner", 32'(owner), 32'd3);
    chk("t1_rst_busy",  32'(busy),  32'd0);
    chk("t1_rst_err",   32'(err),   32'd0);
    nrst = 1'b1;
    @(negedge clk);
    chk("t1_first_gnt",   32'(gnt),   32'b0001);
    chk("t1_first_owner", 32'(owner), 32'd0);

    // 2: rotation, each owner releases after 3 grant cycles
    prev_gnt = '0;
    held = 0;
    for (int i = 0; i < 60; i++) begin
      if (i > 0) @(negedge clk);
      if (gnt != 0) begin
        if (prev_gnt == 0) begin
          order.push_back(int'(owner));
          held = 1;
        end else held++;
        req = (held == 3) ? (4'b1111 & ~gnt) : 4'b1111;
      end else req = 4'b1111;
      prev_gnt = gnt;
      if (order.size() == 5 && held == 3) break;
    end
    chk("t2_count", 32'(order.size()), 32'd5);
    if (order.size() == 5) begin
      chk("t2_ord0", 32'(order[0]), 32'd0);
      chk("t2_ord1", 32'(order[1]), 32'd1);
      chk("t2_ord2", 32'(order[2]), 32'd2);
      chk("t2_ord3", 32'(order[3]), 32'd3);
      chk("t2_ord4", 32'(order[4]), 32'd0);
    end

    // 3: make owner 2, then 0011 must wrap to 0 before 1
    req = 4'b0100;
    wait_grant(20, ok);
    chk("t3_setup_ok", 32'(ok), 32'd1);
    chk("t3_setup_gnt", 32'(gnt), 32'b0100);
    req = 4'b0000;
    repeat (3) @(negedge clk);
    req = 4'b0011;
    @(negedge clk);
    chk("t3_wrap_gnt", 32'(gnt), 32'b0001);
    req = 4'b0010;
    wait_grant(20, ok);
    chk("t3_next_ok",  32'(ok),  32'd1);
    chk("t3_next_gnt", 32'(gnt), 32'b0010);

    // 4: overrun with req[1] held for 12 cycles
    req = 4'b0000;
    repeat (3) @(negedge clk);
    req = 4'b0010;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (gnt[1]) cnt++;
    end
    chk("t4_gnt_cycles", 32'(cnt),  32'd8);
    chk("t4_err_set",    32'(err),  32'd1);
    chk("t4_err_gnt",    32'(gnt),  32'h0);
    chk("t4_err_busy",   32'(busy), 32'd1);
    req = 4'b0000;
    @(negedge clk);
    chk("t4_err_clr",  32'(err),  32'd0);
    chk("t4_idle_busy", 32'(busy), 32'd0);

    // 5: release on the last allowed grant cycle -> GAP, not ERR
    req = 4'b0010;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt[1]) cnt++;
      if (cnt == MAX_HOLD) begin
        req = 4'b0000;
        break;
      end
    end
    chk("t5_cnt", 32'(cnt), 32'(MAX_HOLD));
    @(negedge clk);
    chk("t5_gap_err",  32'(err),  32'd0);
    chk("t5_gap_gnt",  32'(gnt),  32'h0);
    chk("t5_gap_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t5_idle_err", 32'(err), 32'd0);

    // 6: async reset pulse mid-GRANT, between edges
    req = 4'b0001;
    wait_grant(20, ok);
    chk("t6_setup_gnt", 32'(gnt), 32'b0001);
    #2 nrst = 1'b0;
    #1;
    chk("t6_async_gnt",   32'(gnt),   32'h0);
    chk("t6_async_busy",  32'(busy),  32'd0);
    chk("t6_async_owner", 32'(owner), 32'd3);
    #2 nrst = 1'b1;
    @(negedge clk);
    chk("t6_regrant", 32'(gnt), 32'b0001);

    // Randomized requests with occasional reset pulses
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      r = req;
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(5) == 0) r[b] = ~r[b];
      end
      req = r;
      if ($urandom_range(399) == 0) begin
        #3 nrst = 1'b0;
        #3 nrst = 1'b1;
      end
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
